mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the single synchronous RAM behind the CPU's MAR/MDR memory interface. It shares the RAM between the control-unit-driven CPU port and a debug/loader port (program preload, memory dump while halted). It serialises accesses and issues exactly one RAM cycle per granted request. It returns completion with a one-cycle ack pulse.

## Interface
- ADDR_W, 9, RAM word-address width
- DATA_W, 32, data width
- MEM_LAT, 1, RAM read latency in cycles, legal range 1..3

- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU request; held high with fields stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack is high
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same as the cpu_* signals, for the debug port
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid MEM_LAT cycles after the mem_en cycle
- busy  out  1  high whenever the FSM is not IDLE
- owner  out  1  port of the most recent grant: 0 = CPU, 1 = debug

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE:**
  - If either request is high, pick a winner.
  - Latch the winner's we, addr and wdata, and set owner.
  - Go to ISSUE.
  - If no request is high, stay in IDLE.
- **ISSUE:**
  - Drive mem_en=1 for exactly one cycle, with mem_we, mem_addr and mem_wdata taken from the latched values.
  - Write: go to DONE.
  - Read: load the wait counter with MEM_LAT and go to WAIT.
- **WAIT:**
  - Decrement the counter each cycle.
  - On the cycle the counter equals 1, capture mem_rdata into the shared read register rd_q and go to DONE.
- **DONE:**
  - Pulse the winner's ack for one cycle. The other port's ack stays 0.
  - Go to IDLE.
- cpu_rdata and dbg_rdata both drive rd_q. rd_q holds its value until the next read capture. Writes do not modify rd_q.
- mem_addr and mem_wdata hold their latched values outside ISSUE. mem_we is 0 whenever mem_en is 0.
- **Arbitration (default):** fixed priority, debug over CPU. A waiting request is never preempted once granted.
- **Requester rule:** req must be low in the cycle after ack. A registered requester satisfies this. A req still high in IDLE is treated as a new request.
- Requests arriving while busy wait in place. Their fields must stay stable.

## Timing
- Reset state: state=IDLE, owner=0, rd_q=0, wait counter=0, and every output is 0.
- Reset asserted mid-transaction:
  - Immediately return to the reset state.
  - No ack is issued.
  - A RAM write already strobed in ISSUE is not undone.
- Cycle 0 is the IDLE cycle in which req is sampled high.
  - Write: mem_en in cycle 1, ack in cycle 2.
  - Read: mem_en in cycle 1, capture at the end of cycle 1+MEM_LAT, ack with valid rdata in cycle 2+MEM_LAT.
- Throughput:
  - Back-to-back writes from alternating ports: one every 3 cycles (DONE→IDLE→ISSUE).
  - Reads: one every MEM_LAT+3 cycles.
- Simultaneous requests in the same IDLE cycle: resolved by the arbitration rule. The loser is served in the next IDLE after DONE.

## Configuration
- Macro `MEM_ARB_RR_EN`.
- **Defined:** round-robin arbitration.
  - On a tie, the port not equal to owner wins.
  - After reset, owner=0, so the first tie goes to debug.
  - This prevents a continuously requesting debug port from starving the CPU.
- **Undefined:** fixed debug-over-CPU priority. owner is still reported but does not affect arbitration.

## Test plan
- **Single CPU write:** MEM_LAT=1, cpu write of 0xDEADBEEF to 0x05.
  - mem_en=mem_we=1 with addr 0x05 in cycle 1, cpu_ack in cycle 2, dbg_ack=0 throughout.
- **CPU read, MEM_LAT=2:** RAM[0x10]=0x12345678, cpu read of 0x10.
  - mem_en in cycle 1, cpu_ack in cycle 4 with cpu_rdata=0x12345678, busy high in cycles 1–4.
- **Simultaneous writes:** cpu and dbg writes raised in the same cycle, macro undefined.
  - dbg served first (owner=1), cpu_ack three cycles after dbg_ack.
  - With the macro defined, the second tie after that is won by the CPU.
- **Starvation check, macro defined:** dbg_req held continuously with a new request each time, cpu_req high.
  - Grants alternate dbg, cpu, dbg, cpu.
  - Without the macro, the CPU is never acked while dbg is active.
- **Reset mid-read:** reset_n pulsed low during WAIT of a read.
  - All outputs 0 immediately, no ack, and the next request after reset_n rises completes normally.
- **rd_q hold:** read returning 0xA5A5A5A5, then a write of 0x0.
  - cpu_rdata still reads 0xA5A5A5A5 after the write ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug) arbiter and sequencer for a single synchronous RAM.
// Optional round-robin tie-breaking is enabled by defining MEM_ARB_RR_EN.
module mem_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1    // RAM read latency, 1..3
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              owner
);

    localparam int NPORT = 2;
    localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [1:0]        cnt_reg, cnt_next;
    logic [DATA_W-1:0] rd_reg, rd_next;

    // Port 0 = CPU, port 1 = debug; the index doubles as the owner encoding.
    logic [NPORT-1:0]  req_vec;
    logic [NPORT-1:0]  we_vec;
    logic [NPORT-1:0]  ack_vec;
    logic [ADDR_W-1:0] addr_arr  [NPORT];
    logic [DATA_W-1:0] wdata_arr [NPORT];
    logic              win;

    assign req_vec      = {dbg_req, cpu_req};
    assign we_vec       = {dbg_we, cpu_we};
    assign addr_arr[0]  = cpu_addr;
    assign addr_arr[1]  = dbg_addr;
    assign wdata_arr[0] = cpu_wdata;
    assign wdata_arr[1] = dbg_wdata;

    always_comb begin
        win = req_vec[1];
`ifdef MEM_ARB_RR_EN
        // On a tie, hand the grant to whichever port did not win last time.
        if (req_vec == 2'b11) begin
            win = ~owner_reg;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            cnt_reg   <= 2'd0;
            rd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            cnt_reg   <= cnt_next;
            rd_reg    <= rd_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        cnt_next   = cnt_reg;
        rd_next    = rd_reg;

        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    owner_next = win;
                    we_next    = we_vec[win];
                    addr_next  = addr_arr[win];
                    wdata_next = wdata_arr[win];
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (we_reg) begin
                    state_next = DONE;
                end else begin
                    cnt_next   = LAT_LOAD;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 2'd1;
                if (cnt_reg == 2'd1) begin
                    rd_next    = mem_rdata;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode straight from registers so reset clears them at once.
    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_ack
            assign ack_vec[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign cpu_ack   = ack_vec[0];
    assign dbg_ack   = ack_vec[1];
    assign cpu_rdata = rd_reg;
    assign dbg_rdata = rd_reg;

    assign mem_en    = (state_reg == ISSUE);
    assign mem_we    = mem_en & we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

    assign busy      = (state_reg != IDLE);
    assign owner     = owner_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, multi-cycle corner
// sequences, and a randomized run against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW       = 9;
    localparam int DW       = 32;
    localparam int LAT      = 2;
    localparam int RAND_CYC = 1500;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic          cpu_ack, dbg_ack;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy, owner;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    // Synchronous RAM with LAT-cycle read latency; junk on the pipe otherwise.
    logic [DW-1:0] ram   [0:511];
    logic [DW-1:0] rpipe [0:LAT-1];
    bit            ram_init = 1'b0;
    int unsigned   cyc_cnt = 0;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (!ram_init) begin
            for (int i = 0; i < 512; i++) ram[i] <= 32'h1000_0000 + 32'(i);
            ram_init <= 1'b1;
        end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        rpipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : (32'hBAD0_0000 ^ cyc_cnt);
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[LAT-1];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit tie_winner(input bit own);
`ifdef MEM_ARB_RR_EN
        return ~own;
`else
        return 1'b1;
`endif
    endfunction

    task automatic drive(input bit p, input bit rq, input bit w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p) begin
            dbg_req = rq; dbg_we = w; dbg_addr = a; dbg_wdata = d;
        end else begin
            cpu_req = rq; cpu_we = w; cpu_addr = a; cpu_wdata = d;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_en"},    64'(mem_en), 64'd0);
        chk({tag, "_we"},    64'(mem_we), 64'd0);
        chk({tag, "_addr"},  64'(mem_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_cack"},  64'(cpu_ack), 64'd0);
        chk({tag, "_dack"},  64'(dbg_ack), 64'd0);
        chk({tag, "_crd"},   64'(cpu_rdata), 64'd0);
        chk({tag, "_drd"},   64'(dbg_rdata), 64'd0);
        chk({tag, "_owner"}, 64'(owner), 64'd0);
    endtask

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    // One transaction from IDLE; cycle 0 is the negedge where req is raised.
    task automatic do_txn(input vec_t v, output int lat, output int en_cyc,
                          output logic [AW-1:0] en_addr, output logic en_we,
                          output logic [DW-1:0] en_wdata, output logic [DW-1:0] rd_own,
                          output logic [DW-1:0] rd_oth, output bit oth_ack,
                          output bit busy_ok, output logic own_at);
        @(negedge clk);
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        lat = -1; en_cyc = -1; oth_ack = 1'b0; busy_ok = 1'b1;
        en_addr = '0; en_we = 1'b0; en_wdata = '0; rd_own = '0; rd_oth = '0; own_at = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (mem_en) begin
                en_cyc = cyc; en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if ((v.port ? cpu_ack : dbg_ack) === 1'b1) oth_ack = 1'b1;
            if ((v.port ? dbg_ack : cpu_ack) === 1'b1) begin
                lat    = cyc;
                rd_own = v.port ? dbg_rdata : cpu_rdata;
                rd_oth = v.port ? cpu_rdata : dbg_rdata;
                own_at = owner;
                break;
            end
        end
        drive(v.port, 1'b0, 1'b0, '0, '0);
    endtask

    // Both ports raise writes in the same IDLE cycle.
    task automatic run_tie(input logic [AW-1:0] base, output int cpu_at, output int dbg_at);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, base, 32'hC0DE_0000 | 32'(base));
        drive(1'b1, 1'b1, 1'b1, base + 9'd1, 32'hDB60_0000 | 32'(base));
        cpu_at = -1; dbg_at = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1 && cpu_at < 0) begin cpu_at = cyc; drive(1'b0, 1'b0, 1'b0, '0, '0); end
            if (dbg_ack === 1'b1 && dbg_at < 0) begin dbg_at = cyc; drive(1'b1, 1'b0, 1'b0, '0, '0); end
            if (cpu_at >= 0 && dbg_at >= 0) break;
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    vec_t          vecs [9];
    bit            m_owner;
    int            lat, en_cyc, cpu_at, dbg_at, n_gr;
    logic [AW-1:0] en_addr;
    logic          en_we, own_at;
    logic [DW-1:0] en_wdata, rd_own, rd_oth;
    bit            oth_ack, busy_ok, saw_ack, first_w, drained;
    bit            grants [8];
    bit            hold   [2];

    // Random-phase reference model: transaction level, cycle arithmetic only.
    bit            pend [2];
    bit            pwe  [2];
    logic [AW-1:0] paddr [2];
    logic [DW-1:0] pwd   [2];
    logic [DW-1:0] shadow [0:511];
    bit            active, a_port, a_we, exp_en, w;
    int            grant_c, ack_c;
    logic [DW-1:0] a_exp, m_rd, m_wd;
    logic [AW-1:0] m_ad;
    bit            just [2];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        vecs[0] = '{1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b1, 9'h010, 32'h1234_5678, 32'h0000_0000};
        vecs[2] = '{1'b0, 1'b0, 9'h010, 32'h0,         32'h1234_5678};
        vecs[3] = '{1'b0, 1'b0, 9'h005, 32'h0,         32'hDEADBEEF};
        vecs[4] = '{1'b1, 1'b1, 9'h020, 32'hA5A5_A5A5, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 1'b0, 9'h020, 32'h0,         32'hA5A5_A5A5};
        vecs[6] = '{1'b0, 1'b1, 9'h020, 32'h0000_0000, 32'hA5A5_A5A5};
        vecs[7] = '{1'b1, 1'b0, 9'h020, 32'h0,         32'h0000_0000};
        vecs[8] = '{1'b0, 1'b0, 9'h1FF, 32'h0,         32'h1000_01FF};

        repeat (3) @(negedge clk);
        check_zero("rst_hold");
        reset_n = 1'b1;
        @(negedge clk);
        check_zero("rst_idle");
        m_owner = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i], lat, en_cyc, en_addr, en_we, en_wdata, rd_own, rd_oth,
                   oth_ack, busy_ok, own_at);
            $display("txn %0d port=%0d we=%0d addr=%0h lat=%0d rdata=%0h",
                     i, vecs[i].port, vecs[i].we, vecs[i].addr, lat, rd_own);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].we ? 2 : 2 + LAT));
            chk($sformatf("v%0d_en_cyc", i), 64'(en_cyc), 64'd1);
            chk($sformatf("v%0d_addr", i), 64'(en_addr), 64'(vecs[i].addr));
            chk($sformatf("v%0d_we", i), 64'(en_we), 64'(vecs[i].we));
            if (vecs[i].we) chk($sformatf("v%0d_wdata", i), 64'(en_wdata), 64'(vecs[i].wdata));
            chk($sformatf("v%0d_rdata", i), 64'(rd_own), 64'(vecs[i].exp_rdata));
            chk($sformatf("v%0d_rdata_other", i), 64'(rd_oth), 64'(vecs[i].exp_rdata));
            chk($sformatf("v%0d_other_ack", i), 64'(oth_ack), 64'd0);
            chk($sformatf("v%0d_busy", i), 64'(busy_ok), 64'd1);
            chk($sformatf("v%0d_owner", i), 64'(own_at), 64'(vecs[i].port));
            m_owner = vecs[i].port;
        end

        // Tie with owner=CPU, then a debug access, then a tie with owner=debug.
        for (int t = 0; t < 2; t++) begin
            if (t == 1) begin
                do_txn('{1'b1, 1'b1, 9'h050, 32'h0000_5050, 32'h0}, lat, en_cyc, en_addr,
                       en_we, en_wdata, rd_own, rd_oth, oth_ack, busy_ok, own_at);
                chk("tie_pre_lat", 64'(lat), 64'd2);
                m_owner = 1'b1;
            end
            w = tie_winner(m_owner);
            run_tie(9'h040 + 9'(2 * t), cpu_at, dbg_at);
            $display("tie %0d cpu_ack@%0d dbg_ack@%0d", t, cpu_at, dbg_at);
            chk($sformatf("tie%0d_cpu_at", t), 64'(cpu_at), 64'(w ? 5 : 2));
            chk($sformatf("tie%0d_dbg_at", t), 64'(dbg_at), 64'(w ? 2 : 5));
            m_owner = ~w;
            chk($sformatf("tie%0d_owner", t), 64'(owner), 64'(m_owner));
        end

        // Both ports keep re-requesting immediately after each ack.
        first_w = tie_winner(m_owner);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 9'h030, 32'h0000_C000);
        drive(1'b1, 1'b1, 1'b1, 9'h031, 32'h0000_D000);
        n_gr = 0; hold[0] = 1'b0; hold[1] = 1'b0; drained = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if ((p == 1 ? dbg_ack : cpu_ack) === 1'b1) begin
                    if (n_gr < 8) grants[n_gr] = 1'(p);
                    n_gr++;
                    drive(1'(p), 1'b0, 1'b0, '0, '0);
                    hold[p] = 1'b1;
                end else if (hold[p]) begin
                    hold[p] = 1'b0;
                    if (n_gr < 4) drive(1'(p), 1'b1, 1'b1, 9'h030 + 9'(p), 32'(cyc));
                end
            end
            if (n_gr >= 4 && !cpu_req && !dbg_req && busy === 1'b0) begin
                drained = 1'b1;
                break;
            end
        end
        for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_RR_EN
            chk($sformatf("starve_grant%0d", g), (g < n_gr) ? 64'(grants[g]) : 64'd2,
                64'(first_w ^ 1'(g % 2)));
`else
            chk($sformatf("starve_grant%0d", g), (g < n_gr) ? 64'(grants[g]) : 64'd2, 64'd1);
`endif
            $display("starve grant %0d -> port %0d", g, (g < n_gr) ? int'(grants[g]) : -1);
        end
        chk("starve_drain", 64'(drained), 64'd1);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);

        // Reset asserted while a read sits in WAIT.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 9'h005, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_busy_before", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check_zero("rstmid");
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        saw_ack = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (cyc == 2) reset_n = 1'b1;
            if (cpu_ack === 1'b1 || dbg_ack === 1'b1) saw_ack = 1'b1;
        end
        chk("rstmid_no_ack", 64'(saw_ack), 64'd0);
        do_txn('{1'b0, 1'b0, 9'h005, 32'h0, 32'hDEADBEEF}, lat, en_cyc, en_addr, en_we,
               en_wdata, rd_own, rd_oth, oth_ack, busy_ok, own_at);
        $display("post-reset read lat=%0d rdata=%0h", lat, rd_own);
        chk("rstmid_after_lat", 64'(lat), 64'(2 + LAT));
        chk("rstmid_after_rdata", 64'(rd_own), 64'hDEADBEEF);

        // Randomized run from a fresh reset.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 512; i++) shadow[i] = ram[i];
        pend[0] = 1'b0; pend[1] = 1'b0;
        active = 1'b0; grant_c = -10; ack_c = -1;
        m_owner = 1'b0; m_rd = '0; m_wd = '0; m_ad = '0; a_exp = '0; a_port = 1'b0; a_we = 1'b0;
        for (int c = 0; c < RAND_CYC + 400; c++) begin
            @(negedge clk);
            if (active && c == ack_c && !a_we) m_rd = a_exp;
            exp_en = active && (c == grant_c + 1);
            chk("r_mem_en", 64'(mem_en), 64'(exp_en));
            chk("r_mem_we", 64'(mem_we), 64'(exp_en && a_we));
            chk("r_mem_addr", 64'(mem_addr), 64'(m_ad));
            chk("r_mem_wdata", 64'(mem_wdata), 64'(m_wd));
            chk("r_busy", 64'(busy), 64'(active && c > grant_c));
            chk("r_owner", 64'(owner), 64'(m_owner));
            chk("r_cpu_ack", 64'(cpu_ack), 64'(active && c == ack_c && !a_port));
            chk("r_dbg_ack", 64'(dbg_ack), 64'(active && c == ack_c && a_port));
            chk("r_cpu_rdata", 64'(cpu_rdata), 64'(m_rd));
            chk("r_dbg_rdata", 64'(dbg_rdata), 64'(m_rd));
            just[0] = 1'b0; just[1] = 1'b0;
            if (active && c == ack_c) begin
                $display("rand ack c=%0d port=%0d we=%0d rd=%0h", c, a_port, a_we, m_rd);
                pend[a_port] = 1'b0;
                just[a_port] = 1'b1;
                active = 1'b0;
                drive(a_port, 1'b0, 1'b0, '0, '0);
            end
            for (int p = 0; p < 2; p++) begin
                if (c < RAND_CYC && !pend[p] && !just[p] && $urandom_range(3) == 0) begin
                    pend[p]  = 1'b1;
                    pwe[p]   = 1'($urandom_range(1));
                    paddr[p] = 9'($urandom_range(15));
                    pwd[p]   = $urandom;
                    drive(1'(p), 1'b1, pwe[p], paddr[p], pwd[p]);
                end
            end
            if (!active && c > ack_c && (pend[0] || pend[1])) begin
                w       = (pend[0] && pend[1]) ? tie_winner(m_owner) : pend[1];
                active  = 1'b1;
                a_port  = w;
                a_we    = pwe[w];
                grant_c = c;
                ack_c   = c + (a_we ? 2 : 2 + LAT);
                m_owner = w;
                m_ad    = paddr[w];
                m_wd    = pwd[w];
                if (a_we) shadow[paddr[w]] = pwd[w];
                else      a_exp = shadow[paddr[w]];
            end
            if (c >= RAND_CYC && !active && !pend[0] && !pend[1]) break;
        end
        chk("rand_drain", 64'(active || pend[0] || pend[1]), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
